serial_adder_seq: RTL and testbench
===================================

Name: serial_adder_seq

Overview:
- Multi-cycle N-bit adder that processes operands 2 bits per clock through one 2-bit full-adder slice and a registered carry.
- Sits in front of the existing 2-bit Full_Adder and consumes its outputs: it feeds the slice its a/b/cin each cycle and collects {cout, sum}.
- Valid/ready handshake on both sides. Trades latency for area in wide datapaths.

Parameters:
- WIDTH, 8, operand/sum width in bits. Must be even and at least 2.
- SLICES, WIDTH/2, derived (localparam), number of 2-bit slices and the compute cycle count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A (unsigned; also treated as two's complement for overflow)
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  sum bits
- out_cout  output  1  carry-out of MSB
- out_ovf  output  1  signed overflow; present only with the optional feature

Behaviour:
- Reset: rst_n sampled low at a rising edge puts the block in IDLE.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - Internal operand, carry and index registers are cleared.
  - Reset overrides every other input in the same cycle, including mid-CALC or mid-DONE. A result in progress is discarded with no partial output.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1 at an edge: latch in_a, in_b; carry_reg<=in_cin; idx<=0; clear the sum register; go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge computes {c,s} = a[2*idx+1:2*idx] + b[2*idx+1:2*idx] + carry_reg (3-bit result, no truncation).
  - Writes sum[2*idx+1:2*idx]<=s; carry_reg<=c; idx<=idx+1.
  - The slice may be an instance of the 2-bit Full_Adder (ports a, b, cin, cout, sum).
  - On the edge that processes idx==SLICES-1: out_cout<=c and go to DONE.
  - idx is never incremented past SLICES-1; it does not wrap.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum, out_cout (and out_ovf) are held stable until a transfer (out_valid&out_ready) at an edge, then go to IDLE.
  - out_valid is registered; it drops on the edge after the transfer.
- Latency:
  - out_valid is high exactly SLICES cycles after the accepting edge (4 for WIDTH=8).
  - Minimum initiation interval is SLICES+2 cycles. There is no back-to-back accept in DONE.
- in_valid while in_ready=0 is ignored; input values are not sampled.
- Result: {out_cout, out_sum} == in_a + in_b + in_cin, as a WIDTH+1-bit unsigned value.
- in_cin is sampled only in IDLE on the accepting edge.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined:
  - Port out_ovf exists.
  - In the final slice, c_mid = carry out of bit WIDTH-2, computed as (a[W-2]&b[W-2])|(carry_reg&(a[W-2]^b[W-2])).
  - out_ovf <= c_mid ^ c, registered on the same edge as out_cout.
  - out_ovf is cleared by reset, held through DONE, and valid only while out_valid=1.
- When undefined: port and logic are absent. All other behaviour is identical.

Test Plan (WIDTH=8):
- Basic: a=0x5A, b=0x33, cin=0, in_valid for 1 cycle.
  - in_ready drops next cycle.
  - out_valid rises 4 cycles after accept with out_sum=0x8D, out_cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 → out_sum=0x00, out_cout=1, out_ovf=0.
  - a=0xFF, b=0xFF, cin=1 → out_sum=0xFF, out_cout=1.
- Signed overflow (macro on): a=0x7F, b=0x00, cin=1 → out_sum=0x80, out_cout=0, out_ovf=1.
  - a=0x80, b=0x80, cin=0 → out_sum=0x00, out_cout=1, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid with a new operand.
  - out_valid and outputs stay stable; in_ready=0; the pulsed operand is not captured.
  - After out_ready=1, in_ready returns the next cycle.
- Reset mid-operation: drive rst_n=0 on the 2nd CALC cycle.
  - Next cycle: in_ready=1, out_valid=0, out_sum=0, out_cout=0.
  - Then a=0x10, b=0x20, cin=0 → out_sum=0x30, out_cout=0.
- Random: 200 transactions with random a, b, cin and random out_ready stalls.
  - Each result matches a+b+cin; out_valid exactly 4 cycles after each accept; no lost or duplicated transfers.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Multi-cycle WIDTH-bit adder: two bits per clock through one 2-bit slice with a registered carry.
// Optional signed-overflow output out_ovf is built only when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("serial_adder_seq: WIDTH must be even and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;

    // Operands viewed as 2-bit pairs so the active slice is a plain array lookup.
    logic [1:0] a_pairs [SLICES];
    logic [1:0] b_pairs [SLICES];

    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_pairs
            assign a_pairs[gi] = a_reg[2*gi +: 2];
            assign b_pairs[gi] = b_reg[2*gi +: 2];
        end
    endgenerate

    logic [1:0] a_sl;
    logic [1:0] b_sl;
    logic [2:0] slice_res;

    assign a_sl      = a_pairs[idx_reg];
    assign b_sl      = b_pairs[idx_reg];
    assign slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {2'b00, carry_reg};
    assign out_sum   = sum_reg;

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB; only meaningful while the final slice is active.
    logic c_mid;
    assign c_mid = (a_sl[0] & b_sl[0]) | (carry_reg & (a_sl[0] ^ b_sl[0]));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                        in_ready  <= 1'b0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    for (int i = 0; i < SLICES; i++) begin
                        if (idx_reg == IDX_W'(i)) begin
                            sum_reg[2*i +: 2] <= slice_res[1:0];
                        end
                    end
                    carry_reg <= slice_res[2];
                    if (idx_reg == LAST_IDX) begin
                        out_cout  <= slice_res[2];
`ifdef SERIAL_ADDER_OVF_EN
                        out_ovf   <= c_mid ^ slice_res[2];
`endif
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed and random self-checking bench for serial_adder_seq (WIDTH=8).
// Overflow checks are compiled in when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_cin = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic       out_cout;
    logic [7:0] out_sum;
    logic       ovf_now;

    int compared = 0;
    int mismatched = 0;

`ifdef SERIAL_ADDER_OVF_EN
    logic out_ovf;
    assign ovf_now = out_ovf;
`else
    assign ovf_now = 1'b0;
`endif

    serial_adder_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits for in_ready, presents one operand set for one cycle, then waits for out_valid.
    // lat counts edges from the accepting edge to out_valid (20 means it never came).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output int lat, output logic rdy_after);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rdy_after = in_ready;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("txn a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 a, b, cin, out_sum, out_cout, ovf_now, lat);
    endtask

    task automatic finish_xfer();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        compared++; if (out_sum !== 8'h00) begin mismatched++; $display("FAIL reset_out_sum: got %h expected 00", out_sum); end
        compared++; if (out_cout !== 1'b0) begin mismatched++; $display("FAIL reset_out_cout: got %b expected 0", out_cout); end
        compared++; if (ovf_now !== 1'b0) begin mismatched++; $display("FAIL reset_out_ovf: got %b expected 0", ovf_now); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; logic r;
        run_op(8'h5A, 8'h33, 1'b0, lat, r);
        compared++; if (r !== 1'b0) begin mismatched++; $display("FAIL basic_ready_drop: got %b expected 0", r); end
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        compared++; if (out_sum !== 8'h8D) begin mismatched++; $display("FAIL basic_sum: got %h expected 8d", out_sum); end
        compared++; if (out_cout !== 1'b0) begin mismatched++; $display("FAIL basic_cout: got %b expected 0", out_cout); end
        finish_xfer();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_valid_drop: got %b expected 0", out_valid); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL basic_ready_return: got %b expected 1", in_ready); end
    endtask

    task automatic test_carry();
        int lat; logic r;
        run_op(8'hFF, 8'h01, 1'b0, lat, r);
        compared++; if ({out_cout, out_sum} !== 9'h100) begin mismatched++; $display("FAIL carry_ff_01: got %h expected 100", {out_cout, out_sum}); end
        compared++; if (ovf_now !== 1'b0) begin mismatched++; $display("FAIL carry_ff_01_ovf: got %b expected 0", ovf_now); end
        finish_xfer();
        run_op(8'hFF, 8'hFF, 1'b1, lat, r);
        compared++; if ({out_cout, out_sum} !== 9'h1FF) begin mismatched++; $display("FAIL carry_ff_ff_1: got %h expected 1ff", {out_cout, out_sum}); end
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL carry_latency: got %0d expected 4", lat); end
        finish_xfer();
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_overflow();
        int lat; logic r;
        run_op(8'h7F, 8'h00, 1'b1, lat, r);
        compared++; if ({out_cout, out_sum} !== 9'h080) begin mismatched++; $display("FAIL ovf_7f_sum: got %h expected 080", {out_cout, out_sum}); end
        compared++; if (ovf_now !== 1'b1) begin mismatched++; $display("FAIL ovf_7f_flag: got %b expected 1", ovf_now); end
        finish_xfer();
        run_op(8'h80, 8'h80, 1'b0, lat, r);
        compared++; if ({out_cout, out_sum} !== 9'h100) begin mismatched++; $display("FAIL ovf_80_sum: got %h expected 100", {out_cout, out_sum}); end
        compared++; if (ovf_now !== 1'b1) begin mismatched++; $display("FAIL ovf_80_flag: got %b expected 1", ovf_now); end
        finish_xfer();
    endtask
`endif

    task automatic test_backpressure();
        int lat; logic r;
        run_op(8'h12, 8'h34, 1'b0, lat, r);
        for (int i = 0; i < 5; i++) begin
            in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b1;
            in_valid = (i == 1);
            @(posedge clk); #1;
            compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid_held: got %b expected 1", out_valid); end
            compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
            compared++; if ({out_cout, out_sum} !== 9'h046) begin mismatched++; $display("FAIL bp_sum_stable: got %h expected 046", {out_cout, out_sum}); end
        end
        in_valid = 1'b0;
        finish_xfer();
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_ready_return: got %b expected 1", in_ready); end
        repeat (6) @(posedge clk);
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_no_capture: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat; logic r;
        in_a = 8'hC3; in_b = 8'h3C; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
        compared++; if (out_sum !== 8'h00) begin mismatched++; $display("FAIL rmid_out_sum: got %h expected 00", out_sum); end
        compared++; if (out_cout !== 1'b0) begin mismatched++; $display("FAIL rmid_out_cout: got %b expected 0", out_cout); end
        run_op(8'h10, 8'h20, 1'b0, lat, r);
        compared++; if ({out_cout, out_sum} !== 9'h030) begin mismatched++; $display("FAIL rmid_after_sum: got %h expected 030", {out_cout, out_sum}); end
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL rmid_after_latency: got %0d expected 4", lat); end
        finish_xfer();
    endtask

    task automatic test_random();
        int lat; logic r;
        logic [7:0] a, b; logic cin;
        logic [8:0] exp_full;
        logic exp_ovf;
        int stall;
        for (int t = 0; t < 200; t++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            exp_full = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            exp_ovf = (a[7] == b[7]) && (exp_full[7] != a[7]);
            stall = $urandom_range(0, 3);
            run_op(a, b, cin, lat, r);
            compared++; if (lat !== 4) begin mismatched++; $display("FAIL rnd_latency[%0d]: got %0d expected 4", t, lat); end
            compared++; if ({out_cout, out_sum} !== exp_full) begin mismatched++; $display("FAIL rnd_sum[%0d]: got %h expected %h", t, {out_cout, out_sum}, exp_full); end
`ifdef SERIAL_ADDER_OVF_EN
            compared++; if (ovf_now !== exp_ovf) begin mismatched++; $display("FAIL rnd_ovf[%0d]: got %b expected %b", t, ovf_now, exp_ovf); end
`endif
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                compared++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== exp_full) begin mismatched++; $display("FAIL rnd_stall[%0d]: got valid=%b sum=%h expected valid=1 sum=%h", t, out_valid, {out_cout, out_sum}, exp_full); end
            end
            finish_xfer();
            compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rnd_no_dup[%0d]: got %b expected 0", t, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
`ifdef SERIAL_ADDER_OVF_EN
        test_overflow();
`endif
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
